// File: rtl/input_conditioner_pkg.sv
// Shared types and default parameters for the push-button input conditioner.
package input_conditioner_pkg;

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_PEND,
    HELD,
    LONG_HELD,
    RELEASE_PEND
  } ic_state_e;

  localparam int DEF_NUM_INPUTS        = 2;
  localparam int DEF_DEBOUNCE_CYCLES   = 1000;
  localparam int DEF_LONG_PRESS_CYCLES = 50000;
  localparam int DEF_REPEAT_CYCLES     = 0;

  // Bits needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_ch.sv
// One push-button channel: synchroniser, debounce FSM, long-press and auto-repeat timing.
module input_conditioner_ch
  import input_conditioner_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int   LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int   REPEAT_CYCLES     = DEF_REPEAT_CYCLES,
  parameter logic INVERT            = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  input  logic evt_clear,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic evt_pending
);

  localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_PRESS_CYCLES);
  localparam int RPT_W  = cnt_width(REPEAT_CYCLES);

  localparam logic [DB_W-1:0]   DB_DONE   = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_DONE = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [RPT_W-1:0]  RPT_DONE  = RPT_W'(REPEAT_CYCLES);

  ic_state_e         state;
  logic [1:0]        sync_q;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [RPT_W-1:0]  rpt_cnt;
  logic              was_long;

  logic              norm;
  logic [DB_W-1:0]   db_inc;
  logic [HOLD_W-1:0] hold_inc;
  logic [RPT_W-1:0]  rpt_inc;
  logic              db_done;
  logic              press_now;

  assign norm      = sync_q[1] ^ INVERT;
  assign db_inc    = db_cnt + DB_W'(1);
  assign db_done   = (db_inc == DB_DONE);
  assign hold_inc  = (hold_cnt == '1) ? hold_cnt : hold_cnt + HOLD_W'(1);
  assign rpt_inc   = rpt_cnt + RPT_W'(1);
  assign press_now = ((state == RELEASED) || (state == PRESS_PEND)) && norm && db_done;

  // Synchroniser resets to the idle level so an inactive button reads as released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {INVERT, INVERT};
    end else begin
      // NOTE: non-blocking assignments make each flop sample the previous stage's old value.
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RELEASED;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      rpt_cnt       <= '0;
      was_long      <= 1'b0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      evt_pending   <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;

      // A press still visible on press_pulse outranks a clear issued in the same cycle.
      if (press_now || press_pulse) evt_pending <= 1'b1;
      else if (evt_clear)           evt_pending <= 1'b0;

      case (state)
        RELEASED, PRESS_PEND: begin
          if (!norm) begin
            state  <= RELEASED;
            db_cnt <= '0;
          end else if (db_done) begin
            state       <= HELD;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            rpt_cnt     <= '0;
            level       <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            state  <= PRESS_PEND;
            db_cnt <= db_inc;
          end
        end

        HELD, LONG_HELD: begin
          if (!norm) begin
            was_long <= (state == LONG_HELD);
            if (db_done) begin
              state         <= RELEASED;
              db_cnt        <= '0;
              level         <= 1'b0;
              release_pulse <= 1'b1;
            end else begin
              state  <= RELEASE_PEND;
              db_cnt <= db_inc;
            end
          end else begin
            hold_cnt <= hold_inc;
            if (state == HELD) begin
              if (hold_inc == HOLD_DONE) begin
                state      <= LONG_HELD;
                rpt_cnt    <= '0;
                long_pulse <= 1'b1;
              end
            end else if (REPEAT_CYCLES > 0) begin
              if (rpt_inc == RPT_DONE) begin
                rpt_cnt      <= '0;
                repeat_pulse <= 1'b1;
              end else begin
                rpt_cnt <= rpt_inc;
              end
            end
          end
        end

        RELEASE_PEND: begin
          // Hold and repeat counters stay frozen here and resume on return.
          if (norm) begin
            state  <= was_long ? LONG_HELD : HELD;
            db_cnt <= '0;
          end else if (db_done) begin
            state         <= RELEASED;
            db_cnt        <= '0;
            level         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            db_cnt <= db_inc;
          end
        end

        default: begin
          state  <= RELEASED;
          db_cnt <= '0;
          level  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel push-button conditioner: one independent channel per button input.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int                    NUM_INPUTS        = DEF_NUM_INPUTS,
  parameter int                    DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int                    LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int                    REPEAT_CYCLES     = DEF_REPEAT_CYCLES,
  parameter logic [NUM_INPUTS-1:0] INVERT_MASK       = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] btn_raw,
  input  logic [NUM_INPUTS-1:0] evt_clear,
  output logic [NUM_INPUTS-1:0] level,
  output logic [NUM_INPUTS-1:0] press_pulse,
  output logic [NUM_INPUTS-1:0] release_pulse,
  output logic [NUM_INPUTS-1:0] long_pulse,
  output logic [NUM_INPUTS-1:0] repeat_pulse,
  output logic [NUM_INPUTS-1:0] evt_pending
);

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_ch
    input_conditioner_ch #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES),
      .INVERT           (INVERT_MASK[i])
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_raw      (btn_raw[i]),
      .evt_clear    (evt_clear[i]),
      .level        (level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i]),
      .evt_pending  (evt_pending[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: cycle table for debounce/polarity/pending, hand sequences for long press, bounce and reset.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_raw, evt_clear;
  logic [1:0] level, press_pulse, release_pulse, long_pulse, repeat_pulse, evt_pending;

  int n_checks = 0;
  int n_fail   = 0;

  input_conditioner #(
    .NUM_INPUTS(2), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20),
    .REPEAT_CYCLES(5), .INVERT_MASK(2'b10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .evt_clear(evt_clear),
    .level(level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .evt_pending(evt_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] raw, clr, lvl, prs, rel, pnd;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int n, input logic [1:0] raw, clr, lvl, prs, rel, pnd);
    vec_t v;
    v.raw = raw; v.clr = clr; v.lvl = lvl; v.prs = prs; v.rel = rel; v.pnd = pnd;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  function automatic logic [11:0] outs();
    return {level, press_pulse, release_pulse, long_pulse, repeat_pulse, evt_pending};
  endfunction

  initial begin
    rst_n     = 1'b0;
    btn_raw   = 2'b10;
    evt_clear = 2'b00;
    repeat (3) tick();
    check("reset_state", 32'(outs()), 32'h0);
    rst_n = 1'b1;

    // One row per clock: drive inputs, clock once, compare outputs.
    //   n  raw    clr    level  press  release pending
    add(1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(5, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 2'b11, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01);
    add(1, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
    add(1, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    add(5, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    add(1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(3, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(6, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    add(1, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10);
    add(1, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10);
    add(5, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10);
    add(1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10);
    add(1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
    add(1, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      btn_raw   = vecs[i].raw;
      evt_clear = vecs[i].clr;
      tick();
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vecs[i].lvl, vecs[i].prs, vecs[i].rel, 2'b00, 2'b00, vecs[i].pnd}));
    end
    evt_clear = 2'b00;

    // Long press with auto-repeat on channel 0: {press, long, repeat, level}.
    btn_raw = 2'b11;
    for (int c = 1; c <= 46; c++) begin
      tick();
      check($sformatf("long_c%0d", c),
            32'({press_pulse[0], long_pulse[0], repeat_pulse[0], level[0]}),
            32'({c == 6, c == 26, (c == 31 || c == 36 || c == 41 || c == 46), c >= 6}));
    end
    btn_raw = 2'b10;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("long_rel_c%0d", c),
            32'({release_pulse[0], long_pulse[0], repeat_pulse[0], level[0]}),
            32'({c == 6, 1'b0, 1'b0, c < 6}));
    end
    evt_clear = 2'b01;
    tick();
    evt_clear = 2'b00;
    check("pending_cleared", 32'(evt_pending), 32'h0);

    // One-sample dropout while held: no new press, no release, level holds.
    btn_raw = 2'b11;
    repeat (6) tick();
    check("bounce_press", 32'({press_pulse[0], level[0]}), 32'b11);
    btn_raw = 2'b10;
    tick();
    btn_raw = 2'b11;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check($sformatf("bounce_c%0d", c),
            32'({press_pulse[0], release_pulse[0], long_pulse[0], level[0]}), 32'b0001);
    end
    btn_raw = 2'b10;
    repeat (5) tick();
    check("bounce_rel_wait", 32'({release_pulse[0], level[0]}), 32'b01);
    tick();
    check("bounce_rel", 32'({release_pulse[0], level[0]}), 32'b10);

    // Reset while held discards progress; a still-held button presses again afterwards.
    btn_raw = 2'b11;
    repeat (16) tick();
    check("pre_reset_level", 32'(level), 32'h1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outs", 32'(outs()), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check($sformatf("post_reset_c%0d", c),
            32'({press_pulse[0], level[0], evt_pending[0]}),
            32'({c == 6, c == 6, c == 6}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter NUM_INPUTS, default 2, number of independent push-button channels (1..16).
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000, consecutive stable samples required to accept a level change (>=1).
REQ-003 Parameter LONG_PRESS_CYCLES, default 50000, held cycles after press before long_pulse (>DEBOUNCE_CYCLES).
REQ-004 Parameter REPEAT_CYCLES, default 0, auto-repeat period after long press; 0 disables repeat.
REQ-005 Parameter INVERT_MASK, default '0, NUM_INPUTS bits; bit set = channel is active-low.
REQ-006 clk  in  1  sole clock; one clock, all state on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 btn_raw  in  NUM_INPUTS  unsynchronised button inputs.
REQ-009 evt_clear  in  NUM_INPUTS  per-channel clear of evt_pending.
REQ-010 level  out  NUM_INPUTS  debounced, polarity-normalised button state (1 = pressed).
REQ-011 press_pulse  out  NUM_INPUTS  one-cycle pulse on accepted press.
REQ-012 release_pulse  out  NUM_INPUTS  one-cycle pulse on accepted release.
REQ-013 long_pulse  out  NUM_INPUTS  one-cycle pulse when hold reaches LONG_PRESS_CYCLES.
REQ-014 repeat_pulse  out  NUM_INPUTS  one-cycle pulse every REPEAT_CYCLES after long_pulse while held.
REQ-015 evt_pending  out  NUM_INPUTS  sticky flag set by press_pulse.

Function
REQ-016 Each channel SHALL pass btn_raw through a two-flop synchroniser, then XOR with INVERT_MASK to form norm.
REQ-017 Per-channel FSM states: RELEASED, PRESS_PEND, HELD, LONG_HELD, RELEASE_PEND.
REQ-018 RELEASED->PRESS_PEND when norm=1; PRESS_PEND->RELEASED (debounce count cleared) on any norm=0 sample.
REQ-019 Debounce counter counts consecutive qualifying samples; reaching DEBOUNCE_CYCLES completes the transition on that edge.
REQ-020 PRESS_PEND->HELD on completion; level rises and press_pulse asserts on that same edge.
REQ-021 Raw-to-pulse latency for a clean edge SHALL be exactly DEBOUNCE_CYCLES+2 cycles; DEBOUNCE_CYCLES=1 gives 3.
REQ-022 Hold counter starts at 0 on the press edge, increments each cycle in HELD/LONG_HELD, saturates at its maximum.
REQ-023 HELD->LONG_HELD with long_pulse when hold count equals LONG_PRESS_CYCLES; long_pulse fires once per press.
REQ-024 In LONG_HELD with REPEAT_CYCLES>0, repeat_pulse fires every REPEAT_CYCLES cycles after long_pulse; never when 0.
REQ-025 HELD/LONG_HELD->RELEASE_PEND on norm=0; hold and repeat counters pause there.
REQ-026 RELEASE_PEND returns to previous held state on norm=1 with no new press_pulse; counters resume.
REQ-027 RELEASE_PEND->RELEASED on debounce completion; level falls and release_pulse asserts on that edge.
REQ-028 At most one of press/release/long/repeat pulse per channel per cycle; channels fully independent.
REQ-029 evt_pending set on press_pulse, cleared on evt_clear; simultaneous set and clear: set wins.
REQ-030 Counter widths SHALL be $clog2(param+1); no truncation or wrap of any counter.

Reset
REQ-031 On rst_n low all outputs SHALL go 0, FSMs RELEASED, counters 0 immediately (asynchronous).
REQ-032 Synchroniser flops SHALL reset to INVERT_MASK so inactive buttons produce norm=0 after reset.
REQ-033 Reset mid-press discards progress; a still-held button after release of reset produces a fresh press_pulse after DEBOUNCE_CYCLES+2.

Structure
REQ-034 Package input_conditioner_pkg SHALL hold the ic_state_e FSM enum and default parameter constants.
REQ-035 One sub-module input_conditioner_ch (single channel) SHALL be instantiated NUM_INPUTS times via generate.

Verification (NUM_INPUTS=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, REPEAT_CYCLES=5, INVERT_MASK=2'b10)
REQ-036 btn_raw[0] 0->1 held -> press_pulse[0] exactly 6 cycles later, level[0]=1, evt_pending[0]=1.
REQ-037 btn_raw[0] pulses 1 for 3 cycles then 0 -> no pulses, level[0] stays 0.
REQ-038 hold btn_raw[0] 40 cycles -> long_pulse at press+20, repeat_pulse at press+25,+30,+35,+40; release -> release_pulse 6 cycles after raw fall.
REQ-039 btn_raw[1] (active-low) held 1 after reset -> no events; drive 0 -> press_pulse[1] after 6 cycles.
REQ-040 evt_clear[0] asserted on press_pulse[0] cycle -> evt_pending[0]=1; asserted next cycle -> 0.
REQ-041 rst_n low while held 10 cycles -> all outputs 0 at once; rst_n high with button held -> press_pulse 6 cycles later.
